// File: rtl/iso_alu_seq.sv
// Sequential ALU: single-cycle MUL/ADD/SUB, iterative restoring DIV.
// Optional operand isolation holds idle unit inputs steady.
module iso_alu_seq #(
  parameter int W   = 4,
  parameter bit ISO = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [3:0]     sel,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [2*W-1:0] out,
  output logic           out_valid,
  output logic           dz
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_DIV  = 1'b1;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_MUL  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;

  localparam int CW = (W > 2) ? $clog2(W) : 1;

  logic [0:0]     state_q;
  logic [CW-1:0]  cnt_q;
  logic [2:0]     op;
  logic           acc;
  logic           mul_go;
  logic           as_go;
  logic           div_go;
  logic           div_start;
  logic           div_last;

  logic [W-1:0]   mul_a_q;
  logic [W-1:0]   mul_b_q;
  logic [W-1:0]   add_a_q;
  logic [W-1:0]   add_b_q;
  logic [W-1:0]   mul_x;
  logic [W-1:0]   mul_y;
  logic [W-1:0]   as_x;
  logic [W-1:0]   as_y;
  logic           mul_ld;
  logic           as_ld;

  logic [W-1:0]   div_r_q;
  logic [W-1:0]   div_n_q;
  logic [W-1:0]   div_d_q;
  logic [W:0]     shf;
  logic [W:0]     trial;
  logic           qbit;
  logic [W-1:0]   r_nx;
  logic [W-1:0]   n_nx;

  logic [2*W-1:0] prod;
  logic [W:0]     sum;
  logic [W:0]     diff;
  logic [2*W-1:0] res;
  logic           res_dz;

  assign in_ready = (state_q == S_IDLE);
  assign acc      = in_valid & in_ready;

  // sel[3] wins over sel[2] over sel[1] over sel[0]
  always_comb begin
    op = OP_NONE;
    priority case (1'b1)
      sel[3]:  op = OP_MUL;
      sel[2]:  op = OP_ADD;
      sel[1]:  op = OP_DIV;
      sel[0]:  op = OP_SUB;
      default: op = OP_NONE;
    endcase
  end

  assign mul_go    = acc & (op == OP_MUL);
  assign as_go     = acc & ((op == OP_ADD) | (op == OP_SUB));
  assign div_go    = acc & (op == OP_DIV);
  assign div_start = div_go & (b != '0);

  assign mul_ld = ISO ? mul_go : 1'b1;
  assign as_ld  = ISO ? as_go  : 1'b1;

  // Isolated units see the live inputs only in their accept cycle
  assign mul_x = (ISO && !mul_go) ? mul_a_q : a;
  assign mul_y = (ISO && !mul_go) ? mul_b_q : b;
  assign as_x  = (ISO && !as_go)  ? add_a_q : a;
  assign as_y  = (ISO && !as_go)  ? add_b_q : b;

  assign prod = {{W{1'b0}}, mul_x} * {{W{1'b0}}, mul_y};
  assign sum  = {1'b0, as_x} + {1'b0, as_y};
  assign diff = {1'b0, as_x} - {1'b0, as_y};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_a_q <= '0;
      mul_b_q <= '0;
    end else if (mul_ld) begin
      mul_a_q <= a;
      mul_b_q <= b;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      add_a_q <= '0;
      add_b_q <= '0;
    end else if (as_ld) begin
      add_a_q <= a;
      add_b_q <= b;
    end
  end

  // Restoring step: shift in next dividend bit, subtract if it fits
  assign shf   = {div_r_q, div_n_q[W-1]};
  assign trial = shf - {1'b0, div_d_q};
  assign qbit  = ~trial[W];
  assign r_nx  = qbit ? trial[W-1:0] : shf[W-1:0];
  assign n_nx  = {div_n_q[W-2:0], qbit};

  assign div_last = (state_q == S_DIV) &&
                    (cnt_q == CW'(W - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_r_q <= '0;
      div_n_q <= '0;
      div_d_q <= '0;
    end else if (div_start) begin
      state_q <= S_DIV;
      cnt_q   <= '0;
      div_r_q <= '0;
      div_n_q <= a;
      div_d_q <= b;
    end else if (state_q == S_DIV) begin
      div_r_q <= r_nx;
      div_n_q <= n_nx;
      cnt_q   <= cnt_q + 1'b1;
      if (div_last) begin
        state_q <= S_IDLE;
      end
    end
  end

  always_comb begin
    res    = '0;
    res_dz = 1'b0;
    case (op)
      OP_MUL: res = prod;
      OP_ADD: res = {{(W-1){1'b0}}, sum};
      OP_SUB: res = {{(W-1){diff[W]}}, diff};
      OP_DIV: begin
        res    = {a, {W{1'b1}}};
        res_dz = 1'b1;
      end
      default: begin
        res    = '0;
        res_dz = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out       <= '0;
      dz        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (acc && !div_start) begin
        out       <= res;
        dz        <= res_dz;
        out_valid <= 1'b1;
      end else if (div_last) begin
        out       <= {r_nx, n_nx};
        dz        <= 1'b0;
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: doc/iso_alu_seq.md
ISO_ALU_SEQ -- requirements
Module: iso_alu_seq

Interface
REQ-001 Parameter W, default 4, operand width; legal range 2..16.
REQ-002 Parameter ISO, default 1, operand isolation enable (1 = unselected unit operands held, 0 = all unit operands follow inputs).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 a  input  W  operand A, unsigned.
REQ-006 b  input  W  operand B, unsigned.
REQ-007 sel  input  4  op select, priority sel[3] > sel[2] > sel[1] > sel[0].
REQ-008 in_valid  input  1  request strobe.
REQ-009 in_ready  output  1  block can accept a request.
REQ-010 out  output  2W  registered result.
REQ-011 out_valid  output  1  one-cycle pulse, new result on out.
REQ-012 dz  output  1  divide-by-zero flag for the current out.

Function
REQ-013 Request accepted on a rising edge where in_valid=1 and in_ready=1; otherwise a, b and sel are ignored.
REQ-014 Op decode at acceptance: sel[3] MUL, else sel[2] ADD, else sel[1] DIV, else sel[0] SUB, else NONE.
REQ-015 MUL: out = a*b, full 2W bits.
REQ-016 ADD: out = a+b, zero-extended W+1-bit sum.
REQ-017 SUB: out = a-b, two's complement, sign-extended to 2W bits.
REQ-018 DIV: out = {remainder[W-1:0], quotient[W-1:0]}.
REQ-019 NONE: out = 0, dz = 0.
REQ-020 MUL, ADD, SUB, NONE: out, dz and out_valid updated on the accepting edge; out_valid high for exactly the next cycle; in_ready stays 1.
REQ-021 FSM states IDLE and DIV; in_ready = 1 only in IDLE.
REQ-022 DIV with b != 0: accepting edge captures a, b and enters DIV; restoring divider runs one quotient bit per edge for W edges; the W-th edge writes out, sets dz=0, pulses out_valid and returns to IDLE.
REQ-023 DIV latency: out_valid high in the cycle after edge k+W, where k is the accepting edge; in_ready low for cycles k+1..k+W and high again in the out_valid cycle.
REQ-024 DIV with b = 0: no iteration, single-cycle as REQ-020; quotient all ones, remainder = a, dz = 1.
REQ-025 in_valid during DIV is ignored, not queued; out and dz hold their previous values until DIV completes.
REQ-026 Back-to-back single-cycle requests are accepted every cycle; out_valid stays high continuously.
REQ-027 out and dz hold their last value between results.
REQ-028 With ISO=1, each unit's operand register (multiplier, adder/subtractor, divider) loads only on acceptance of its own op and holds otherwise.
REQ-029 ISO must not change out, dz, out_valid or in_ready timing for any stimulus.

Reset
REQ-030 rst low asynchronously forces out=0, dz=0, out_valid=0, FSM=IDLE and clears the divider and isolation registers.
REQ-031 With rst low, in_ready=1.
REQ-032 A DIV in progress at reset is aborted; no out_valid is produced for it after release.
REQ-033 The first request can be accepted on the first rising edge after rst goes high.

Verification (W=4)
REQ-034 MUL: a=15, b=15, sel=1000 -> out=0xE1, dz=0, out_valid one cycle after accept.
REQ-035 SUB and priority: a=3, b=5, sel=0001 -> out=0xFE; a=2, b=3, sel=1111 -> out=0x06.
REQ-036 DIV: a=13, b=3, sel=0010 -> in_ready low 4 cycles; then out=0x14, dz=0, out_valid once.
REQ-037 DIV by zero: a=9, b=0, sel=0010 -> next cycle out=0x9F, dz=1, in_ready never drops.
REQ-038 Busy and reset: ADD request issued while DIV is busy -> ignored, DIV result unchanged; rst pulsed low at cycle 2 of a DIV -> out=0, no out_valid afterwards.
REQ-039 Isolation: ISO=1, stream ADD requests while toggling a and b -> multiplier and divider operand registers constant; ISO=0 and ISO=1 runs give identical output traces.
